// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit front end for a single-port data memory.
// Handles byte/half/word access, sub-word stores by read-modify-write, and misalignment errors.

module lsu_dmem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size_i,
  input  logic [1:0]  boff_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  rd_byte_i,
  output logic [7:0]  byte_o
);
  localparam logic [1:0] LID = 2'(LANE);

  logic       en;
  logic [7:0] src;

  // Store data arrives right-aligned, so sub-word sizes pick from the low bytes.
  always_comb begin
    en  = 1'b0;
    src = wdata_i[8*LANE +: 8];
    case (size_i)
      2'b00: begin
        en  = (boff_i == LID);
        src = wdata_i[7:0];
      end
      2'b01: begin
        en  = (boff_i[1] == LID[1]);
        src = wdata_i[8*(LANE%2) +: 8];
      end
      2'b10:   en = 1'b1;
      default: en = 1'b0;
    endcase
    byte_o = en ? src : rd_byte_i;
  end
endmodule

module lsu_dmem_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W+1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e                        state_q, state_d;
  logic                          we_q, uns_q, err_q;
  logic [1:0]                    size_q;
  logic [ADDR_W+1:0]             addr_q;
  logic [31:0]                   wdata_q, rdword_q, rdata_q, ld_data;
  logic [7:0]                    ld_byte;
  logic [15:0]                   ld_half;
  logic [NUM_LANES-1:0][7:0]     merged;
  logic                          req_err, accept;

  assign req_err = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b01) & req_addr_i[0])
                 | ((req_size_i == 2'b10) & (|req_addr_i[1:0]));
  assign accept  = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_err)                             state_d = RESP;
        else if (req_we_i && req_size_i == 2'b10) state_d = WRITE;
        else                                     state_d = READ;
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) & ~rst_i;
    rsp_valid_o = (state_q == RESP);
    rsp_err_o   = (state_q == RESP) & err_q;
    mem_we_o    = (state_q == WRITE);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == READ || state_q == WRITE) mem_addr_o = addr_q[ADDR_W+1:2];
    if (state_q == WRITE)                    mem_wdata_o = merged;
  end

  assign rsp_rdata_o = rdata_q;

  // Word stores enable every lane, so the merge path also covers them.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_dmem_lane #(.LANE(g)) u_lane (
      .size_i    (size_q),
      .boff_i    (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rd_byte_i (rdword_q[8*g +: 8]),
      .byte_o    (merged[g])
    );
  end

  always_comb begin
    ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdword_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (state_q == READ) rdword_q <= mem_rdata_i;
      // Response data is loaded once on entry to RESP and then held.
      if (state_d == RESP && state_q != RESP)
        rdata_q <= (state_q == READ && !we_q) ? ld_data : 32'h0;
    end
  end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized bench for lsu_dmem_ctrl against a byte-addressed reference memory.
// Checks latency, response data/error, write traffic and final memory contents.

module tb_lsu_dmem_ctrl;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = '0;
  logic              req_uns = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] dmem [32];
  logic [7:0]  rm [128];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          we_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [ADDR_W-1:0] last_waddr = '0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
      we_cnt         <= we_cnt + 1;
      last_waddr     <= mem_addr;
      last_wdata     <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rm[4*w+3], rm[4*w+2], rm[4*w+1], rm[4*w]};
  endfunction

  // Reference: byte-wise memory, natural alignment rule, spec latencies.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [6:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rdata);
    int nb, lat, we0, a;
    logic err;
    logic [31:0] exp_rd;
    int exp_lat, exp_we;
    a  = int'(addr);
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err = (size == 2'b11) || (a % nb != 0);
    exp_rd = 32'h0;
    if (err)          begin exp_lat = 1; exp_we = 0; end
    else if (!we)     begin exp_lat = 2; exp_we = 0; end
    else if (nb == 4) begin exp_lat = 2; exp_we = 1; end
    else              begin exp_lat = 3; exp_we = 1; end
    if (!err && !we) begin
      for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(rm[a+i]) << (8*i));
      if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'h1 << (8*nb)) - 32'h1);
    end

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom; req_addr = 7'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      chk("ready_busy", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'h1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("ready_resp", 32'(req_ready), 32'h0);
    got_rdata = rsp_rdata;
    chk("we_pulses", 32'(we_cnt - we0), 32'(exp_we));

    if (!err && we)
      for (int i = 0; i < nb; i++) rm[a+i] = wdata[8*i +: 8];
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("ready_after", 32'(req_ready), 32'h1);
    chk("rdata_hold", rsp_rdata, exp_rd);
    chk("mem_word", dmem[a/4], ref_word(a/4));
  endtask

  initial begin
    logic [31:0] rd;
    int acc [2];
    int nacc, cyc;
    for (int i = 0; i < 32; i++) dmem[i] = '0;
    for (int i = 0; i < 128; i++) rm[i] = '0;

    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_memwe", 32'(mem_we), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ready_post_rst", 32'(req_ready), 32'h1);

    run_txn(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, rd);
    chk("sw_waddr", 32'(last_waddr), 32'h2);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    run_txn(1'b1, 2'b00, 1'b0, 7'h09, 32'h000000AA, rd);
    chk("sb_wdata", last_wdata, 32'hDEADAAEF);
    run_txn(1'b0, 2'b00, 1'b0, 7'h0B, 32'h0, rd); chk("lb", rd, 32'hFFFFFFDE);
    run_txn(1'b0, 2'b00, 1'b1, 7'h0B, 32'h0, rd); chk("lbu", rd, 32'h000000DE);
    run_txn(1'b0, 2'b01, 1'b0, 7'h0A, 32'h0, rd); chk("lh", rd, 32'hFFFFDEAD);
    run_txn(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0, rd); chk("lhu", rd, 32'h0000DEAD);
    run_txn(1'b0, 2'b10, 1'b0, 7'h06, 32'h0, rd); chk("lw_mis", rd, 32'h0);
    run_txn(1'b0, 2'b11, 1'b0, 7'h00, 32'h0, rd); chk("sz11", rd, 32'h0);

    // Reset during the WRITE cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
    req_addr = 7'h08; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_state_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", 32'(mem_we), 32'h0);
    chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mid_valid2", 32'(rsp_valid), 32'h0);
    chk("rst_word2", dmem[2], ref_word(2));
    @(negedge clk); rst = 1'b0;
    #1 chk("ready_rst2", 32'(req_ready), 32'h1);
    @(posedge clk); #1 chk("ready_rst2b", 32'(req_ready), 32'h1);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 7'h08;
    nacc = 0; cyc = 0;
    while (nacc < 2 && cyc < 20) begin
      if (req_ready) begin acc[nacc] = cyc; nacc++; end
      @(negedge clk); cyc++;
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(nacc), 32'h2);
    if (nacc == 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'h3);
    repeat (4) @(negedge clk);

    for (int t = 0; t < 400; t++) begin
      logic [1:0] sz;
      logic [6:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      run_txn(1'($urandom), sz, 1'($urandom), ad, $urandom, rd);
    end

    for (int w = 0; w < 32; w++) chk("final_mem", dmem[w], ref_word(w));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/lsu_dmem_ctrl.md
LSU_DMEM_CTRL -- requirements
Module: lsu_dmem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 5, word-address width on the memory side; byte address width is ADDR_W+2.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  in  1  core presents a load/store request.
REQ-005 req_ready_o  out  1  high only in IDLE; a request is accepted on an edge where req_valid_i and req_ready_o are both high.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  loads only: 1 zero-extends, 0 sign-extends.
REQ-009 req_addr_i  in  ADDR_W+2  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
REQ-011 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata_o  out  32  load result; 0 for stores and errors; holds until the next response.
REQ-013 rsp_err_o  out  1  valid with rsp_valid_o; 1 = misaligned or illegal-size request.
REQ-014 mem_we_o  out  1  to data memory MemRW; 1 writes mem_wdata_o at mem_addr_o on the next rising edge.
REQ-015 mem_addr_o  out  ADDR_W  word address to data memory.
REQ-016 mem_wdata_o  out  32  write data to data memory.
REQ-017 mem_rdata_i  in  32  data memory read data; combinational from mem_addr_o while mem_we_o=0.

Function
REQ-018 FSM states are IDLE, READ, WRITE, RESP; the block accepts at most one request at a time.
REQ-019 On acceptance the block registers we, size, unsigned, addr and wdata; inputs are ignored until the block returns to IDLE.
REQ-020 IDLE -> RESP with error when the request is misaligned: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11.
REQ-021 IDLE -> READ for aligned loads and aligned byte/halfword stores; IDLE -> WRITE for aligned word stores.
REQ-022 READ: mem_we_o=0, mem_addr_o=addr[ADDR_W+1:2]; mem_rdata_i is captured at the end of the cycle; load -> RESP, sub-word store -> WRITE.
REQ-023 Sub-word store merge: replace byte lane addr[1:0] (byte) or halfword lane addr[1] (half) of the captured word with req_wdata_i low bits; other lanes keep their read value.
REQ-024 WRITE: mem_we_o=1 for exactly one cycle, mem_addr_o=word address, mem_wdata_o=merged word (or req_wdata_i for word stores); -> RESP.
REQ-025 Load extraction selects the byte/halfword lane from addr[1:0], then sign- or zero-extends to 32 bits per req_unsigned_i; word loads return the word unchanged.
REQ-026 RESP: rsp_valid_o=1 for one cycle; -> IDLE unconditionally, with no response backpressure.
REQ-027 Latency from the acceptance edge to rsp_valid_o high: error 1 cycle; load 2; word store 2; sub-word store 3.
REQ-028 mem_we_o is 0 in every state except WRITE; mem_addr_o and mem_wdata_o are 0 in IDLE and RESP.
REQ-029 An error response performs no memory access: mem_we_o stays 0 and rsp_rdata_o=0.
REQ-030 Back-to-back operation: req_ready_o rises in the cycle after RESP, so the minimum spacing between acceptances is latency+1 cycles.

Reset
REQ-031 While rst_i=1, the FSM is forced to IDLE immediately (asynchronously): req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, and all capture registers are 0.
REQ-032 req_ready_o=1 from the first cycle after rst_i deasserts.
REQ-033 Reset mid-operation drops the pending request: no response is issued, and a reset during WRITE leaves memory unwritten because mem_we_o falls before the edge.

Verification
REQ-034 After memory reset to zero, store word 0xDEADBEEF at addr 0x08 -> mem_we_o high one cycle with mem_addr_o=2 and mem_wdata_o=0xDEADBEEF; rsp_valid_o 2 cycles after acceptance; rsp_rdata_o=0, rsp_err_o=0.
REQ-035 Then store byte 0x000000AA at addr 0x09 -> READ of word 2, then WRITE of 0xDEADAAEF; rsp_valid_o 3 cycles after acceptance.
REQ-036 Then load addr 0x0B byte signed -> 0xFFFFFFDE; byte unsigned -> 0x000000DE; addr 0x0A half signed -> 0xFFFFDEAD; half unsigned -> 0x0000DEAD; each with rsp_valid_o 2 cycles after acceptance.
REQ-037 Load word at addr 0x06 -> rsp_err_o=1, rsp_rdata_o=0, no mem_we_o pulse; rsp_valid_o 1 cycle after acceptance. Size 11 at addr 0x00 -> same result.
REQ-038 Assert rst_i during the WRITE cycle of a byte store of 0x55 to addr 0x08 -> mem_we_o drops at once, no rsp_valid_o, word 2 unchanged, req_ready_o=1 the cycle after reset deasserts.
REQ-039 Hold req_valid_i high with two queued loads -> second acceptance occurs exactly 3 cycles after the first; req_ready_o low throughout READ and RESP.
